mii_rx_deframer: RTL and testbench
==================================

// Module: mii_rx_deframer
// PURPOSE
//  Receive-side framer: the counterpart of the nibble-level MII transmit framer. Samples
//  MII RX nibbles, finds preamble/SFD and packs nibbles low-first into bytes. Checks the
//  FCS (CRC-32) and strips it, then emits the frame payload (DA..last data byte) as a
//  byte AXI-Stream. tuser is set on the tlast beat when the frame is bad. Sits between
//  the PHY RX pins and the packet parser; one clock domain (PHY rx clock).
// PARAMETERS
//  MIN_PREAMBLE_NIBBLES  2     minimum count of 0x5 nibbles before the SFD nibble 0xD
//  MIN_FRAME_BYTES       64    min bytes after SFD, FCS included; shorter -> bad frame
//  MAX_FRAME_BYTES       1522  max bytes after SFD, FCS included; longer -> truncate, bad
// PORTS
//  clock             in   1   PHY RX clock (2.5/25 MHz); all logic on rising edge
//  reset             in   1   synchronous, active-high
//  mii_d             in   4   RX nibble, bit0 first in time order of a byte's low nibble
//  mii_dv            in   1   RX data valid
//  mii_er            in   1   RX error from PHY
//  maxis_tdata       out  8   payload byte
//  maxis_tvalid      out  1   one-cycle beat strobe; no tready (stream cannot stall)
//  maxis_tlast       out  1   last payload byte of frame
//  maxis_tuser       out  1   valid only with tlast: 1 = drop frame
//  stat_frame_ok     out  1   1-cycle pulse with tlast when tuser=0
//  stat_frame_err    out  1   1-cycle pulse per bad frame, incl. frames emitting no beats
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, delay line empty, CRC reg 0xFFFFFFFF, flags clear.
//  Reset mid-frame: output stops at once, no tlast is produced. Stay in IDLE until dv=0.
//  Inputs are registered once before use, giving one fixed cycle of input latency.
//  FSM (evaluated on registered inputs):
//   IDLE : dv=0 -> IDLE. dv=1 & d=5 -> PRE with pcnt=1. dv=1 & other -> DROP.
//   PRE  : d=5 -> pcnt++ (saturating). d=D & pcnt>=MIN_PREAMBLE_NIBBLES -> DATA.
//          Any other nibble, or dv=0 -> DROP (or IDLE if dv=0). No beat, no stat pulse.
//   DATA : nibble phase toggles. Low nibble is stored, high nibble completes a byte.
//          Each byte goes into the CRC and a 5-byte delay line; bcnt++ (saturates at MAX+1).
//          When a byte enters a full line, the oldest byte is emitted (tvalid, tlast=0),
//            so at most one beat every 2 cycles.
//          err sticky <- mii_er while dv=1.
//          bcnt reaches MAX_FRAME_BYTES+1 -> emit oldest byte, tlast=1 tuser=1 -> DROP.
//          dv=0 -> END.
//   END  : one cycle. If line full (bcnt>=5), emit oldest byte with tlast=1 and
//          tuser = err | odd_nibble | (bcnt<MIN_FRAME_BYTES) | (crc!=RESIDUE).
//          If bcnt<5, emit nothing and pulse stat_frame_err.
//          Then clear line, CRC and flags -> IDLE (dv=1 here -> DROP).
//   DROP : wait for dv=0 -> IDLE. No output.
//  odd_nibble: END is reached with the low-nibble phase pending (dribble nibble is discarded).
//  CRC: reflected CRC-32, poly 0xEDB88320, init 0xFFFFFFFF, byte-wise LSB first,
//   run over the data bytes and the FCS bytes. Good frame <=> final register == 0xDEBB20E3.
//  Latency: a payload byte is emitted 1 cycle after the high nibble of the byte 5 later
//   is registered. tlast appears 2 cycles after the pins show dv=0.
//  Back-to-back frames with IFG >= 1 nibble are each decoded correctly.
//  mii_er in IDLE/PRE is ignored.
// STRUCTURE
//  Package mii_pkg: NIBBLE_PREAMBLE=4'h5, NIBBLE_SFD=4'hD, CRC32_POLY_REFL, CRC32_INIT,
//   CRC32_RESIDUE=32'hDEBB20E3, and the FSM state enum type rx_state_t.
//  Sub-module crc32_d8: byte-parallel CRC step with clear/enable (shared with the TX framer).
//  Delay line, nibble packer, FSM and counters stay inline.
// TESTING
//  1 Reference frame: 7x 0x55 + 0xD5, 60-byte payload 00..3B, correct FCS
//    -> 60 beats 00..3B, tlast on 0x3B, tuser=0, one stat_frame_ok.
//  2 Same frame with bit 0 of payload byte 10 flipped -> 60 beats, tuser=1, stat_frame_err.
//  3 mii_er=1 for one cycle mid-payload -> tuser=1. Frame with an extra trailing nibble
//    -> tuser=1 (odd_nibble).
//  4 Runt: 20 bytes incl. good FCS -> 16 beats, tuser=1. A 3-byte frame -> no beat and a
//    single stat_frame_err pulse.
//  5 Oversize: 1600 bytes -> exactly 1518 beats, last has tlast=1 tuser=1, nothing further
//    until dv drops. A following good frame then decodes ok.
//  6 Preamble 0x5,0x3,... -> no output. Reset asserted at payload byte 30 -> beats stop,
//    no tlast. The next frame (dv low first) decodes ok.
//  Every test: tvalid never in 2 consecutive cycles, and tuser/stat are only asserted
//  together with tlast (except the no-beat runt pulse).

Source files
------------

// File: rtl/mii_pkg.sv
// ---------------------------------------------------------------------------
// mii_pkg
//   Shared constants and types for the MII receive/transmit framers:
//   preamble/SFD nibble values, reflected CRC-32 constants, the receive FSM
//   state type and a byte-wide CRC-32 update function.
// ---------------------------------------------------------------------------
package mii_pkg;

   localparam logic [3:0]  NIBBLE_PREAMBLE = 4'h5;
   localparam logic [3:0]  NIBBLE_SFD      = 4'hD;

   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
   // Register value left after running a good frame's data and FCS through the CRC
   localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_DATA,
      ST_END,
      ST_DROP
   } rx_state_t;

   // One byte of reflected CRC-32, LSB first
   function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'h000000, data};
      for (int unsigned i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/crc32_d8.sv
// ---------------------------------------------------------------------------
// crc32_d8
//   Byte-parallel reflected CRC-32 register.
//   clk_i   in   clock, rising edge
//   rst_i   in   synchronous active-high reset, loads CRC32_INIT
//   clr_i   in   reload CRC32_INIT (wins over en_i)
//   en_i    in   fold data_i into the register
//   data_i  in   8-bit data byte
//   crc_o   out  current register value (not inverted)
// ---------------------------------------------------------------------------
module crc32_d8
   import mii_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic [7:0]  data_i,
   output logic [31:0] crc_o
);

   logic [31:0] crc_q;
   logic [31:0] crc_d;

   always_comb begin
      crc_d = crc_q;
      if (clr_i) begin
         crc_d = CRC32_INIT;
      end else if (en_i) begin
         crc_d = crc32_step(crc_q, data_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         crc_q <= CRC32_INIT;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/mii_rx_deframer.sv
// ---------------------------------------------------------------------------
// mii_rx_deframer
//   MII receive deframer: registers RX nibbles, locates preamble/SFD, packs
//   nibbles low-first into bytes, checks and strips the FCS and emits the
//   payload (DA..last data byte) as an unstallable byte stream.
//   clock / reset        PHY RX clock, synchronous active-high reset
//   mii_d/dv/er          MII RX nibble, data valid, PHY error
//   maxis_tdata/tvalid   payload byte and one-cycle beat strobe
//   maxis_tlast/tuser    last beat of frame; tuser=1 on tlast marks a bad frame
//   stat_frame_ok/err    one pulse per good / bad frame
// ---------------------------------------------------------------------------
module mii_rx_deframer
   import mii_pkg::*;
#(
   parameter int unsigned MIN_PREAMBLE_NIBBLES = 2,
   parameter int unsigned MIN_FRAME_BYTES      = 64,
   parameter int unsigned MAX_FRAME_BYTES      = 1522
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] mii_d,
   input  logic       mii_dv,
   input  logic       mii_er,
   output logic [7:0] maxis_tdata,
   output logic       maxis_tvalid,
   output logic       maxis_tlast,
   output logic       maxis_tuser,
   output logic       stat_frame_ok,
   output logic       stat_frame_err
);

   // Four FCS bytes plus the byte being released
   localparam int unsigned LINE_DEPTH = 5;
   localparam int unsigned BCNT_W     = $clog2(MAX_FRAME_BYTES + 2);
   localparam int unsigned PCNT_W     = $clog2(MIN_PREAMBLE_NIBBLES + 2);

   localparam logic [PCNT_W-1:0] PCNT_SAT  = PCNT_W'(MIN_PREAMBLE_NIBBLES);
   localparam logic [BCNT_W-1:0] BCNT_FULL = BCNT_W'(LINE_DEPTH);
   localparam logic [BCNT_W-1:0] BCNT_MIN  = BCNT_W'(MIN_FRAME_BYTES);
   localparam logic [BCNT_W-1:0] BCNT_MAX  = BCNT_W'(MAX_FRAME_BYTES);
   localparam logic [BCNT_W-1:0] BCNT_SAT  = BCNT_W'(MAX_FRAME_BYTES + 1);

   // Input pipeline: free-running so the post-reset dv check sees real pins
   logic [3:0]        d_q;
   logic              dv_q;
   logic              er_q;

   rx_state_t         state_q, state_d;
   logic              wait_q;
   logic [PCNT_W-1:0] pcnt_q, pcnt_d;
   logic              phase_q, phase_d;
   logic [3:0]        low_q, low_d;
   logic              err_q, err_d;
   logic [BCNT_W-1:0] bcnt_q, bcnt_d;
   logic [7:0]        line_q [LINE_DEPTH];

   logic [31:0]       crc;
   logic              crc_clr, crc_en;

   logic              byte_done;
   logic [7:0]        new_byte;
   logic              line_full;
   logic              frame_bad;
   logic              emit, last, user, ok, bad;

   logic [7:0]        tdata_q;
   logic              tvalid_q, tlast_q, tuser_q, ok_q, err_out_q;

   always_ff @(posedge clock) begin
      d_q  <= mii_d;
      dv_q <= mii_dv;
      er_q <= mii_er;
   end

   always_comb begin
      byte_done = (state_q == ST_DATA) && dv_q && phase_q;
      new_byte  = {d_q, low_q};
      line_full = bcnt_q >= BCNT_FULL;
      frame_bad = err_q | phase_q | (bcnt_q < BCNT_MIN) | (crc != CRC32_RESIDUE);
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (dv_q && !wait_q) begin
               state_d = (d_q == NIBBLE_PREAMBLE) ? ST_PRE : ST_DROP;
            end
         end
         ST_PRE: begin
            if (!dv_q) begin
               state_d = ST_IDLE;
            end else if (d_q == NIBBLE_PREAMBLE) begin
               state_d = ST_PRE;
            end else if ((d_q == NIBBLE_SFD) && (pcnt_q >= PCNT_SAT)) begin
               state_d = ST_DATA;
            end else begin
               state_d = ST_DROP;
            end
         end
         ST_DATA: begin
            if (!dv_q) begin
               state_d = ST_END;
            end else if (byte_done && (bcnt_q == BCNT_MAX)) begin
               state_d = ST_DROP;
            end
         end
         ST_END: begin
            // A one-nibble IFG puts the next preamble's first nibble here, so
            // END accepts it like IDLE would instead of dropping the frame.
            if (dv_q) begin
               state_d = (d_q == NIBBLE_PREAMBLE) ? ST_PRE : ST_DROP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DROP: begin
            if (!dv_q) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      emit = 1'b0;
      last = 1'b0;
      user = 1'b0;
      ok   = 1'b0;
      bad  = 1'b0;
      case (state_q)
         ST_DATA: begin
            if (byte_done && line_full) begin
               emit = 1'b1;
               // This byte is MAX+1: truncate and flag
               if (bcnt_q == BCNT_MAX) begin
                  last = 1'b1;
                  user = 1'b1;
                  bad  = 1'b1;
               end
            end
         end
         ST_END: begin
            if (line_full) begin
               emit = 1'b1;
               last = 1'b1;
               user = frame_bad;
               ok   = !frame_bad;
               bad  = frame_bad;
            end else begin
               bad  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // ---------------- Datapath next state ----------------
   always_comb begin
      pcnt_d  = pcnt_q;
      phase_d = phase_q;
      low_d   = low_q;
      err_d   = err_q;
      bcnt_d  = bcnt_q;
      crc_clr = 1'b0;
      crc_en  = 1'b0;
      case (state_q)
         ST_IDLE, ST_END: begin
            pcnt_d  = PCNT_W'(1);
            phase_d = 1'b0;
            err_d   = 1'b0;
            bcnt_d  = '0;
            crc_clr = 1'b1;
         end
         ST_PRE: begin
            if ((d_q == NIBBLE_PREAMBLE) && (pcnt_q < PCNT_SAT)) begin
               pcnt_d = pcnt_q + PCNT_W'(1);
            end
         end
         ST_DATA: begin
            if (dv_q) begin
               err_d   = err_q | er_q;
               phase_d = !phase_q;
               if (!phase_q) begin
                  low_d = d_q;
               end else begin
                  crc_en = 1'b1;
                  if (bcnt_q != BCNT_SAT) begin
                     bcnt_d = bcnt_q + BCNT_W'(1);
                  end
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wait_q    <= 1'b1;
         pcnt_q    <= '0;
         phase_q   <= 1'b0;
         low_q     <= '0;
         err_q     <= 1'b0;
         bcnt_q    <= '0;
         tdata_q   <= '0;
         tvalid_q  <= 1'b0;
         tlast_q   <= 1'b0;
         tuser_q   <= 1'b0;
         ok_q      <= 1'b0;
         err_out_q <= 1'b0;
      end else begin
         // Held after reset until the pins show a gap, so a frame cut by reset is not re-entered
         wait_q    <= wait_q & dv_q;
         pcnt_q    <= pcnt_d;
         phase_q   <= phase_d;
         low_q     <= low_d;
         err_q     <= err_d;
         bcnt_q    <= bcnt_d;
         tdata_q   <= emit ? line_q[LINE_DEPTH-1] : '0;
         tvalid_q  <= emit;
         tlast_q   <= last;
         tuser_q   <= user;
         ok_q      <= ok;
         err_out_q <= bad;
      end
   end

   // Delay line contents; occupancy is tracked by bcnt_q
   always_ff @(posedge clock) begin
      if (byte_done) begin
         line_q[0] <= new_byte;
         for (int unsigned i = 1; i < LINE_DEPTH; i++) begin
            line_q[i] <= line_q[i-1];
         end
      end
   end

   crc32_d8 u_crc (
      .clk_i  (clock),
      .rst_i  (reset),
      .clr_i  (crc_clr),
      .en_i   (crc_en),
      .data_i (new_byte),
      .crc_o  (crc)
   );

   assign maxis_tdata    = tdata_q;
   assign maxis_tvalid   = tvalid_q;
   assign maxis_tlast    = tlast_q;
   assign maxis_tuser    = tuser_q;
   assign stat_frame_ok  = ok_q;
   assign stat_frame_err = err_out_q;

endmodule

// File: tb/tb_mii_rx_deframer.sv
// ---------------------------------------------------------------------------
// tb_mii_rx_deframer
//   Drives MII frames (directed and randomized) into mii_rx_deframer and
//   compares the output stream and status pulses with a frame-level model.
// ---------------------------------------------------------------------------
module tb_mii_rx_deframer;

   localparam int unsigned MINB    = 64;
   localparam int unsigned MAXB    = 1522;
   localparam int unsigned TRUNC_N = MAXB - 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] mii_d = 4'h0;
   logic       mii_dv = 1'b0;
   logic       mii_er = 1'b0;
   logic [7:0] maxis_tdata;
   logic       maxis_tvalid, maxis_tlast, maxis_tuser;
   logic       stat_frame_ok, stat_frame_err;

   typedef struct packed {
      logic [7:0] d;
      logic       last;
      logic       user;
   } beat_t;

   beat_t       exp_q[$];
   logic [7:0]  frm[$];
   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc = 0;
   int unsigned exp_solo = 0, solo_seen = 0;
   int unsigned beats_seen = 0, tlast_seen = 0, stat_seen = 0, ok_seen = 0;
   int unsigned drop_cyc = 0, last_cyc = 0;
   logic        prev_valid = 1'b0;

   always #5 clock = ~clock;

   mii_rx_deframer #(
      .MIN_PREAMBLE_NIBBLES (2),
      .MIN_FRAME_BYTES      (MINB),
      .MAX_FRAME_BYTES      (MAXB)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .mii_d          (mii_d),
      .mii_dv         (mii_dv),
      .mii_er         (mii_er),
      .maxis_tdata    (maxis_tdata),
      .maxis_tvalid   (maxis_tvalid),
      .maxis_tlast    (maxis_tlast),
      .maxis_tuser    (maxis_tuser),
      .stat_frame_ok  (stat_frame_ok),
      .stat_frame_err (stat_frame_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // Output monitor
   always @(negedge clock) begin
      beat_t e;
      if (maxis_tvalid) begin
         check("beat_gap", 32'(prev_valid), 32'd0);
         beats_seen++;
         if (maxis_tlast) begin
            tlast_seen++;
            last_cyc = cyc;
         end
         check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("tdata", 32'(maxis_tdata), 32'(e.d));
            check("tlast", 32'(maxis_tlast), 32'(e.last));
            check("tuser", 32'(maxis_tuser), 32'(e.user));
            check("stat_ok", 32'(stat_frame_ok), 32'(e.last && !e.user));
            check("stat_err", 32'(stat_frame_err), 32'(e.last && e.user));
         end
      end else begin
         check("idle_flags", 32'({maxis_tlast, maxis_tuser, stat_frame_ok}), 32'd0);
         if (stat_frame_err) solo_seen++;
      end
      if (stat_frame_ok || stat_frame_err) stat_seen++;
      if (stat_frame_ok) ok_seen++;
      prev_valid = maxis_tvalid;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic dv, input logic [3:0] d, input logic er);
      tick();
      mii_dv = dv;
      mii_d  = d;
      mii_er = er;
   endtask

   // FCS of the first n bytes of frm, fed bit by bit
   function automatic logic [31:0] fcs_of(input int unsigned n);
      logic [31:0] c;
      logic [7:0]  b;
      c = 32'hFFFFFFFF;
      for (int unsigned i = 0; i < n; i++) begin
         b = frm[i];
         for (int unsigned k = 0; k < 8; k++) begin
            c = (c[0] ^ b[k]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
         end
      end
      return ~c;
   endfunction

   task automatic build(input int unsigned plen, input bit ramp);
      logic [31:0] f;
      frm.delete();
      for (int unsigned i = 0; i < plen; i++) frm.push_back(ramp ? 8'(i) : 8'($urandom));
      f = fcs_of(plen);
      for (int unsigned k = 0; k < 4; k++) frm.push_back(f[8*k +: 8]);
   endtask

   task automatic build_raw(input int unsigned n);
      frm.delete();
      for (int unsigned i = 0; i < n; i++) frm.push_back(8'($urandom));
   endtask

   // Frame-level expectation: payload = all bytes but the last four
   task automatic model(input bit pre_ok, input bit er, input bit extra);
      int unsigned n;
      logic [31:0] rx_fcs;
      bit          user;
      n = frm.size();
      if (!pre_ok) return;
      if (n > MAXB) begin
         for (int unsigned i = 0; i < TRUNC_N; i++)
            exp_q.push_back('{d: frm[i], last: (i == TRUNC_N - 1), user: (i == TRUNC_N - 1)});
      end else if (n >= 5) begin
         rx_fcs = {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
         user = er || extra || (n < MINB) || (fcs_of(n - 4) != rx_fcs);
         for (int unsigned i = 0; i < n - 4; i++)
            exp_q.push_back('{d: frm[i], last: (i == n - 5), user: (i == n - 5) && user});
      end else begin
         exp_solo++;
      end
   endtask

   // er_nib: data nibble index carrying mii_er (-1 none, -2 whole preamble)
   // rst_nib: data nibble index at which reset is raised for two cycles (-1 none)
   task automatic send(input int unsigned pre_fives, input bit bad_pre, input int er_nib,
                       input bit extra, input int unsigned ifg, input int rst_nib);
      logic [7:0] b;
      for (int unsigned i = 0; i < pre_fives; i++)
         drive(1'b1, (bad_pre && i == 1) ? 4'h3 : 4'h5, er_nib == -2);
      drive(1'b1, 4'hD, er_nib == -2);
      for (int i = 0; i < 2 * frm.size(); i++) begin
         b = frm[i/2];
         drive(1'b1, (i % 2 == 0) ? b[3:0] : b[7:4], er_nib == i);
         if (i == rst_nib) reset = 1'b1;
         if (i == rst_nib + 2) reset = 1'b0;
      end
      if (extra) drive(1'b1, 4'($urandom), 1'b0);
      drive(1'b0, 4'h0, 1'b0);
      drop_cyc = cyc + 1;
      for (int unsigned i = 1; i < ifg; i++) drive(1'b0, 4'h0, 1'b0);
   endtask

   task automatic drain(input string tag);
      repeat (12) tick();
      check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_solo_err"}, solo_seen, exp_solo);
   endtask

   initial begin
      int unsigned b0, t0, s0, nb, plen, n, sel;
      int          er_nib;
      bit          bad_pre, extra, corrupt;

      repeat (3) tick();
      check("reset_ctrl", 32'({maxis_tvalid, maxis_tlast, maxis_tuser, stat_frame_ok, stat_frame_err}), 32'd0);
      check("reset_tdata", 32'(maxis_tdata), 32'd0);
      reset = 1'b0;
      repeat (3) tick();

      // Reference frame
      build(60, 1'b1);
      model(1'b1, 1'b0, 1'b0);
      send(15, 1'b0, -1, 1'b0, 4, -1);
      drain("ref");
      check("ref_tlast_latency", last_cyc - drop_cyc, 32'd2);
      check("ref_ok_count", ok_seen, 32'd1);

      // Bad FCS
      build(60, 1'b1);
      frm[10] = frm[10] ^ 8'h01;
      model(1'b1, 1'b0, 1'b0);
      send(15, 1'b0, -1, 1'b0, 4, -1);
      drain("badfcs");

      // mii_er mid payload, then dribble nibble
      build(60, 1'b1);
      model(1'b1, 1'b1, 1'b0);
      send(15, 1'b0, 41, 1'b0, 4, -1);
      drain("er");
      build(60, 1'b1);
      model(1'b1, 1'b0, 1'b1);
      send(15, 1'b0, -1, 1'b1, 4, -1);
      drain("odd");

      // Runts
      build(16, 1'b1);
      model(1'b1, 1'b0, 1'b0);
      send(15, 1'b0, -1, 1'b0, 4, -1);
      drain("runt20");
      build_raw(3);
      model(1'b1, 1'b0, 1'b0);
      send(15, 1'b0, -1, 1'b0, 4, -1);
      drain("runt3");

      // Oversize then good frame
      build(1596, 1'b0);
      model(1'b1, 1'b0, 1'b0);
      send(15, 1'b0, -1, 1'b0, 4, -1);
      drain("oversize");
      build(60, 1'b1);
      model(1'b1, 1'b0, 1'b0);
      send(15, 1'b0, -1, 1'b0, 4, -1);
      drain("after_oversize");

      // Broken preamble and too-short preamble
      build(60, 1'b1);
      model(1'b0, 1'b0, 1'b0);
      send(15, 1'b1, -1, 1'b0, 4, -1);
      build(60, 1'b1);
      model(1'b0, 1'b0, 1'b0);
      send(1, 1'b0, -1, 1'b0, 4, -1);
      drain("badpre");

      // Reset at payload byte 30: a prefix of beats, then silence, no tlast
      build(60, 1'b1);
      for (int unsigned i = 0; i < 60; i++) exp_q.push_back('{d: frm[i], last: 1'b0, user: 1'b0});
      b0 = beats_seen;
      t0 = tlast_seen;
      s0 = stat_seen;
      send(15, 1'b0, -1, 1'b0, 4, 60);
      repeat (12) tick();
      nb = beats_seen - b0;
      check("rst_beats_in_range", 32'(nb >= 20 && nb <= 30), 32'd1);
      check("rst_no_tlast", tlast_seen - t0, 32'd0);
      check("rst_no_stat", stat_seen - s0, 32'd0);
      exp_q.delete();
      build(60, 1'b1);
      model(1'b1, 1'b0, 1'b0);
      send(15, 1'b0, -1, 1'b0, 4, -1);
      drain("after_reset");

      // Preamble-time mii_er is ignored
      build(60, 1'b0);
      model(1'b1, 1'b0, 1'b0);
      send(7, 1'b0, -2, 1'b0, 2, -1);
      drain("er_in_pre");

      // Randomized back-to-back frames
      for (int f = 0; f < 10; f++) begin
         sel = $urandom_range(0, 4);
         if (sel == 0) begin
            build_raw($urandom_range(1, 4));
         end else begin
            plen = $urandom_range(1, 100);
            build(plen, 1'b0);
            corrupt = ($urandom_range(0, 3) == 0);
            if (corrupt) frm[$urandom_range(0, plen - 1)] ^= 8'(1 << $urandom_range(0, 7));
         end
         n       = frm.size();
         er_nib  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * n - 1)) : -1;
         extra   = ($urandom_range(0, 3) == 0);
         bad_pre = ($urandom_range(0, 7) == 0);
         model(!bad_pre, er_nib >= 0, extra);
         send($urandom_range(2, 15), bad_pre, er_nib, extra, $urandom_range(1, 3), -1);
      end
      drain("random");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
